scope_frame_packer: RTL and testbench

Consumes the triggered 12-bit sample stream (data/vld/last) produced by the scope capture path and buffers one complete frame in on-chip RAM. Once the frame is closed, it emits the frame as a framed byte stream toward the UDP transmit layer of the Ethernet stack. It is the receiving end of the scope sample stream and the sending end of the scope payload interface.

---
 rtl/scope_frame_packer.sv | 218 +++++++++++++++++++++
 tb/tb_scope_frame_packer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_frame_packer.sv
// Buffers one triggered 12-bit sample frame in RAM, then streams it as header + body bytes.
// Optional trailing 16-bit checksum enabled by defining SCOPE_FRAME_PACKER_CSUM_EN.
module scope_frame_packer #(
  parameter int unsigned P_MAX_LEN = 1000,
  parameter int unsigned P_ADDR_W  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_ad_data,
  input  logic        i_ad_data_vld,
  input  logic        i_ad_data_last,
  output logic [7:0]  o_udp_data,
  output logic        o_udp_valid,
  output logic        o_udp_last,
  input  logic        i_udp_ready,
  output logic [15:0] o_udp_len,
  output logic        o_frame_busy,
  output logic [15:0] o_drop_cnt
);

`ifdef SCOPE_FRAME_PACKER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HEAD, S_BODY, S_CSUM, S_DONE} state_t;
  localparam logic CSUM_ON = 1'b1;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HEAD, S_BODY, S_DONE} state_t;
  localparam logic CSUM_ON = 1'b0;
`endif
  localparam logic [15:0] TAIL_LEN = CSUM_ON ? 16'd8 : 16'd6;
  localparam logic [15:0] MAX_M1   = 16'(P_MAX_LEN - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] pos;
  logic [7:0]  seq;
  logic        trunc;
  logic [7:0]  samp;

  logic [11:0] mem [0:(1 << P_ADDR_W) - 1];
  logic [11:0] rd_q;
  logic        rd_en;
  logic [P_ADDR_W-1:0] rd_addr;

  logic        xfer, wr_en, drop, close;
  logic        load_hi, load_lo, body_end, lo_is_last;
  logic [15:0] close_cnt, body_last_idx;
  logic [7:0]  hdr_next, body_byte;

  assign xfer          = o_udp_valid & i_udp_ready;
  assign body_last_idx = (cnt << 1) - 16'd1;
  assign body_end      = (pos == body_last_idx);
  assign lo_is_last    = !CSUM_ON && ((pos + 16'd1) == body_last_idx);
  assign load_hi       = xfer && ((state == S_HEAD && pos == 16'd5) ||
                                  (state == S_BODY && pos[0] && !body_end));
  assign load_lo       = xfer && (state == S_BODY) && !pos[0];
  assign body_byte     = load_hi ? {{4{rd_q[11]}}, rd_q[11:8]} : samp;
  assign close         = i_ad_data_vld && i_ad_data_last && (state == S_IDLE || state == S_FILL);
  assign close_cnt     = (state == S_IDLE) ? 16'd1 : (wr_en ? cnt + 16'd1 : cnt);

  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    if (i_ad_data_vld) begin
      unique case (state)
        S_IDLE:  wr_en = 1'b1;
        S_FILL:  if (trunc) drop = 1'b1; else wr_en = 1'b1;
        default: drop = 1'b1;
      endcase
    end
  end

  // Byte following the header byte currently on the output.
  always_comb begin
    unique case (pos[2:0])
      3'd0:    hdr_next = 8'h5A;
      3'd1:    hdr_next = seq;
      3'd2:    hdr_next = {6'd0, CSUM_ON, trunc};
      3'd3:    hdr_next = cnt[15:8];
      3'd4:    hdr_next = cnt[7:0];
      default: hdr_next = '0;
    endcase
  end

  // Sample 0 is fetched during HEAD; each hi-byte load fetches the sample after it,
  // so the RAM latency is hidden and rd_q holds steady through stalls.
  always_comb begin
    rd_en   = (state == S_HEAD) || load_hi;
    rd_addr = '0;
    if (state == S_HEAD)
      rd_addr = load_hi ? P_ADDR_W'(1) : '0;
    else
      rd_addr = P_ADDR_W'(pos[15:1] + 15'd2);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[cnt[P_ADDR_W-1:0]] <= i_ad_data;
  end

  always_ff @(posedge i_clk) begin
    if (rd_en) rd_q <= mem[rd_addr];
  end

`ifdef SCOPE_FRAME_PACKER_CSUM_EN
  logic [15:0] sum;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  sum <= '0;
    else if (state == S_DONE)   sum <= '0;
    else if (load_hi || load_lo) sum <= sum + {8'd0, body_byte};
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      pos          <= '0;
      seq          <= '0;
      trunc        <= 1'b0;
      samp         <= '0;
      o_udp_data   <= '0;
      o_udp_valid  <= 1'b0;
      o_udp_last   <= 1'b0;
      o_udp_len    <= '0;
      o_frame_busy <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      if (load_hi) samp <= rd_q[7:0];

      unique case (state)
        S_IDLE: begin
          if (i_ad_data_vld) begin
            cnt          <= 16'd1;
            trunc        <= (MAX_M1 == 16'd0) && !i_ad_data_last;
            o_frame_busy <= 1'b1;
            state        <= S_FILL;
          end
        end
        S_FILL: begin
          if (wr_en) begin
            cnt <= cnt + 16'd1;
            if (!i_ad_data_last && cnt == MAX_M1) trunc <= 1'b1;
          end
        end
        S_HEAD: begin
          if (xfer) begin
            if (load_hi) begin
              state      <= S_BODY;
              pos        <= '0;
              o_udp_data <= body_byte;
            end else begin
              pos        <= pos + 16'd1;
              o_udp_data <= hdr_next;
            end
          end
        end
        S_BODY: begin
          if (xfer && body_end) begin
`ifdef SCOPE_FRAME_PACKER_CSUM_EN
            state       <= S_CSUM;
            pos         <= '0;
            o_udp_data  <= sum[15:8];
            o_udp_last  <= 1'b0;
`else
            state       <= S_DONE;
            o_udp_valid <= 1'b0;
            o_udp_data  <= '0;
            o_udp_last  <= 1'b0;
`endif
          end else if (load_hi) begin
            pos        <= pos + 16'd1;
            o_udp_data <= body_byte;
            o_udp_last <= 1'b0;
          end else if (load_lo) begin
            pos        <= pos + 16'd1;
            o_udp_data <= body_byte;
            o_udp_last <= lo_is_last;
          end
        end
`ifdef SCOPE_FRAME_PACKER_CSUM_EN
        S_CSUM: begin
          if (xfer) begin
            if (pos == 16'd0) begin
              pos        <= 16'd1;
              o_udp_data <= sum[7:0];
              o_udp_last <= 1'b1;
            end else begin
              state       <= S_DONE;
              o_udp_valid <= 1'b0;
              o_udp_data  <= '0;
              o_udp_last  <= 1'b0;
            end
          end
        end
`endif
        S_DONE: begin
          state        <= S_IDLE;
          seq          <= seq + 8'd1;
          cnt          <= '0;
          trunc        <= 1'b0;
          o_udp_len    <= '0;
          o_frame_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Closing sample overrides the FILL/IDLE bookkeeping above and opens the header.
      if (close) begin
        state       <= S_HEAD;
        pos         <= '0;
        o_udp_valid <= 1'b1;
        o_udp_data  <= 8'hA5;
        o_udp_last  <= 1'b0;
        o_udp_len   <= TAIL_LEN + (close_cnt << 1);
      end
    end
  end

endmodule

// File: tb/tb_scope_frame_packer.sv
// Randomized bench for scope_frame_packer against a frame-level reference model.
module tb_scope_frame_packer;
  localparam int unsigned MAXL = 8;
`ifdef SCOPE_FRAME_PACKER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] ad_data = '0;
  logic        ad_vld = 1'b0, ad_last = 1'b0, udp_ready = 1'b1;
  logic [7:0]  udp_data;
  logic        udp_valid, udp_last, frame_busy;
  logic [15:0] udp_len, drop_cnt;

  scope_frame_packer #(.P_MAX_LEN(MAXL), .P_ADDR_W(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ad_data(ad_data), .i_ad_data_vld(ad_vld), .i_ad_data_last(ad_last),
    .o_udp_data(udp_data), .o_udp_valid(udp_valid), .o_udp_last(udp_last),
    .i_udp_ready(udp_ready), .o_udp_len(udp_len),
    .o_frame_busy(frame_busy), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  logic [11:0] smp_q[$];
  logic [7:0]  exp_q[$], got_q[$];
  int exp_seq = 0, exp_drop = 0, exp_len = 0;
  int frames_done = 0, last_pos = 0, stall_err = 0, gap_err = 0, len_err = 0;
  logic [15:0] got_len = '0;
  bit rdy_rand = 1'b0;

  // Reference: frame bytes derived from the sample list and the framing rules.
  function automatic void build_exp();
    int n, stored, sum, val;
    logic [15:0] v16;
    logic [15:0] s16;
    n = smp_q.size();
    stored = (n > int'(MAXL)) ? int'(MAXL) : n;
    sum = 0;
    s16 = 16'(stored);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(exp_seq % 256));
    exp_q.push_back(8'(((n > int'(MAXL)) ? 1 : 0) + (CSUM_ON ? 2 : 0)));
    exp_q.push_back(s16[15:8]);
    exp_q.push_back(s16[7:0]);
    for (int i = 0; i < stored; i++) begin
      val = int'(smp_q[i]);
      if (val >= 2048) val = val - 4096;
      v16 = 16'(val);
      exp_q.push_back(v16[15:8]);
      exp_q.push_back(v16[7:0]);
      sum = sum + int'(v16[15:8]) + int'(v16[7:0]);
    end
    if (CSUM_ON) begin
      v16 = 16'(sum % 65536);
      exp_q.push_back(v16[15:8]);
      exp_q.push_back(v16[7:0]);
    end
    exp_drop = exp_drop + (n - stored);
    exp_len = exp_q.size();
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      udp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects transferred bytes and counts protocol violations.
  initial begin
    bit in_frame = 0, stalled = 0;
    logic [7:0] st_data = '0;
    logic st_last = 0;
    logic [15:0] st_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0; stalled = 0;
      end else begin
        if (stalled && (!udp_valid || udp_data !== st_data || udp_last !== st_last || udp_len !== st_len))
          stall_err++;
        if (in_frame && !udp_valid) gap_err++;
        if (udp_valid) begin
          if (!in_frame) begin in_frame = 1; got_len = udp_len; end
          if (udp_len !== got_len) len_err++;
          stalled = !udp_ready;
          st_data = udp_data; st_last = udp_last; st_len = udp_len;
          if (udp_ready) begin
            got_q.push_back(udp_data);
            if (udp_last) begin
              in_frame = 0;
              if (last_pos == 0) last_pos = got_q.size();
              frames_done++;
            end
          end
        end else stalled = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic fill_random(input int n);
    smp_q.delete();
    for (int i = 0; i < n; i++) smp_q.push_back(12'($urandom_range(0, 4095)));
  endtask

  task automatic send_frame();
    got_q.delete();
    last_pos = 0;
    for (int i = 0; i < smp_q.size(); i++) begin
      @(posedge clk); #1;
      ad_vld = 1'b1; ad_data = smp_q[i]; ad_last = (i == smp_q.size() - 1);
    end
    @(posedge clk); #1;
    ad_vld = 1'b0; ad_last = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frames_done >= target && !frame_busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({udp_data, udp_valid, udp_last, udp_len, frame_busy, drop_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b len=%0d busy=%b drop=%0d, required all 0",
               udp_data, udp_valid, udp_last, udp_len, frame_busy, drop_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (udp_valid !== 1'b0 || frame_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got v=%b busy=%b, required 0 0", udp_valid, frame_busy);
    end
  endtask

  task automatic test_basic();
    int busy_cycles = 0;
    int target;
    rdy_rand = 0;
    smp_q = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
    build_exp();
    target = frames_done + 1;
    send_frame();
    n_checks++;
    if (udp_valid !== 1'b1 || udp_data !== 8'hA5) begin
      n_errors++;
      $display("FAIL basic_first_byte: got v=%b data=%h, required 1 a5 one cycle after close", udp_valid, udp_data);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_busy) busy_cycles++; else break;
    end
    n_checks++;
    if (busy_cycles != exp_len + 1 || frames_done != target) begin
      n_errors++;
      $display("FAIL basic_cycles: got %0d busy cycles, %0d frames, required %0d, %0d",
               busy_cycles, frames_done, exp_len + 1, target);
    end
    n_checks++;
    if (got_len !== 16'(CSUM_ON ? 16 : 14) || last_pos != exp_len) begin
      n_errors++;
      $display("FAIL basic_len_last: got len=%0d last@%0d, required %0d", got_len, last_pos, exp_len);
    end
    n_checks++;
    if (got_q.size() != exp_len) begin
      n_errors++;
      $display("FAIL basic_count: got %0d bytes, required %0d", got_q.size(), exp_len);
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL basic_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic test_stall();
    bit ok;
    rdy_rand = 1; stall_err = 0; gap_err = 0; len_err = 0;
    smp_q = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
    build_exp();
    send_frame();
    wait_done(frames_done + 1, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL stall_timeout: frame not completed, required completion"); end
    n_checks++;
    if (stall_err != 0 || gap_err != 0 || len_err != 0) begin
      n_errors++;
      $display("FAIL stall_protocol: got stall=%0d gap=%0d len=%0d violations, required 0", stall_err, gap_err, len_err);
    end
    n_checks++;
    if (got_q != exp_q || last_pos != exp_len) begin
      n_errors++;
      $display("FAIL stall_bytes: got %0d bytes last@%0d seq=%h, required %0d bytes seq=%h",
               got_q.size(), last_pos, (got_q.size() > 2) ? got_q[2] : 8'h00, exp_len, exp_q[2]);
    end
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic test_trunc();
    bit ok;
    int lens[2] = '{8, 10};
    rdy_rand = 0;
    foreach (lens[k]) begin
      fill_random(lens[k]);
      build_exp();
      send_frame();
      wait_done(frames_done + 1, ok);
      n_checks++;
      if (!ok || got_q != exp_q || got_len !== 16'(exp_len) || last_pos != exp_len) begin
        n_errors++;
        $display("FAIL trunc_frame_n%0d: got %0d bytes flags=%h len=%0d, required %0d bytes flags=%h len=%0d",
                 lens[k], got_q.size(), (got_q.size() > 3) ? got_q[3] : 8'h00, got_len,
                 exp_len, exp_q[3], exp_len);
      end
      n_checks++;
      if (drop_cnt !== 16'(exp_drop)) begin
        n_errors++;
        $display("FAIL trunc_drop_n%0d: got %0d, required %0d", lens[k], drop_cnt, exp_drop);
      end
      exp_seq = (exp_seq + 1) % 256;
    end
  endtask

  task automatic test_drop_in_body();
    bit ok;
    rdy_rand = 0;
    fill_random(6);
    build_exp();
    send_frame();
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (udp_valid !== 1'b1) begin n_errors++; $display("FAIL body_active: got valid=%b, required 1", udp_valid); end
    for (int i = 0; i < 3; i++) begin
      ad_vld = 1'b1; ad_data = 12'($urandom_range(0, 4095)); ad_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ad_vld = 1'b0; ad_last = 1'b0;
    exp_drop = exp_drop + 3;
    wait_done(frames_done + 1, ok);
    n_checks++;
    if (!ok || got_q != exp_q || drop_cnt !== 16'(exp_drop)) begin
      n_errors++;
      $display("FAIL body_drop: got %0d bytes drop=%0d, required %0d bytes drop=%0d",
               got_q.size(), drop_cnt, exp_len, exp_drop);
    end
    exp_seq = (exp_seq + 1) % 256;
    fill_random(2);
    build_exp();
    send_frame();
    wait_done(frames_done + 1, ok);
    n_checks++;
    if (!ok || got_q != exp_q || last_pos != exp_len) begin
      n_errors++;
      $display("FAIL body_next_frame: got %0d bytes seq=%h, required %0d bytes seq=%h",
               got_q.size(), (got_q.size() > 2) ? got_q[2] : 8'h00, exp_len, exp_q[2]);
    end
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rdy_rand = 0;
    fill_random(6);
    build_exp();
    send_frame();
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({udp_data, udp_valid, udp_last, udp_len, frame_busy, drop_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got data=%h v=%b l=%b len=%0d busy=%b drop=%0d, required all 0",
               udp_data, udp_valid, udp_last, udp_len, frame_busy, drop_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_seq = 0; exp_drop = 0;
    fill_random(2);
    build_exp();
    send_frame();
    wait_done(frames_done + 1, ok);
    n_checks++;
    if (!ok || got_q != exp_q || last_pos != exp_len) begin
      n_errors++;
      $display("FAIL reset_mid_next: got %0d bytes seq=%h, required %0d bytes seq=%h",
               got_q.size(), (got_q.size() > 2) ? got_q[2] : 8'h00, exp_len, exp_q[2]);
    end
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    rdy_rand = 1; stall_err = 0; gap_err = 0; len_err = 0;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 11);
      fill_random(n);
      build_exp();
      send_frame();
      wait_done(frames_done + 1, ok);
      n_checks++;
      if (!ok || got_q != exp_q || got_len !== 16'(exp_len) || last_pos != exp_len || drop_cnt !== 16'(exp_drop)) begin
        n_errors++;
        $display("FAIL b2b_frame%0d_n%0d: got %0d bytes len=%0d last@%0d drop=%0d, required %0d bytes drop=%0d",
                 k, n, got_q.size(), got_len, last_pos, drop_cnt, exp_len, exp_drop);
      end
      exp_seq = (exp_seq + 1) % 256;
    end
    n_checks++;
    if (stall_err != 0 || gap_err != 0 || len_err != 0) begin
      n_errors++;
      $display("FAIL b2b_protocol: got stall=%0d gap=%0d len=%0d violations, required 0", stall_err, gap_err, len_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_trunc();
    test_drop_in_body();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
